// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that serialises debounced key presses into a small event FIFO.
// Optional macro KEY_EVT_GAP_EN adds a per-event inter-grant cycle count on evt_gap.
module key_event_arbiter #(
    parameter int NUM_KEYS   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int KW        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_pulse,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KW-1:0]       evt_code,
    output logic [NUM_KEYS-1:0] pending,
    output logic                overrun,
    input  logic                clr_overrun
`ifdef KEY_EVT_GAP_EN
    ,
    output logic [15:0]         evt_gap
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [KW-1:0]       last;
    logic [KW-1:0]       grant_idx;
    logic                grant_en;
    logic [NUM_KEYS-1:0] grant_vec;
    logic [KW-1:0]       code_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         fifo_count;
    logic                push;
    logic                pop;
    logic                drop;

    // First requesting key found searching upward from base+1, wrapping at NUM_KEYS.
    function automatic logic [KW-1:0] rr_pick(input logic [NUM_KEYS-1:0] req,
                                              input logic [KW-1:0]       base);
        logic [KW-1:0] pick;
        logic [KW-1:0] ci;
        logic          hit;
        int            c;
        pick = '0;
        hit  = 1'b0;
        for (int off = 1; off <= NUM_KEYS; off++) begin
            c = int'(base) + off;
            if (c >= NUM_KEYS) c = c - NUM_KEYS;
            ci = c[KW-1:0];
            if (!hit && req[ci]) begin
                hit  = 1'b1;
                pick = ci;
            end
        end
        return pick;
    endfunction

    // A full FIFO blocks the grant even if the head is popped this cycle.
    always_comb begin
        grant_idx = rr_pick(pending, last);
        grant_en  = (|pending) && (fifo_count < FULL_COUNT);
        grant_vec = grant_en ? (NUM_KEYS'(1) << grant_idx) : '0;
        push      = grant_en;
        drop      = |(key_pulse & pending & ~grant_vec);
    end

    // Handshake: an event transfers on any cycle where evt_valid && evt_ready;
    // evt_valid never depends on evt_ready, and evt_code holds until the transfer.
    assign evt_valid = (fifo_count != '0);
    assign pop       = evt_valid && evt_ready;
    assign evt_code  = code_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            last       <= KW'(NUM_KEYS - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) code_mem[i] <= '0;
        end else begin
            // A fresh pulse on the key being granted re-arms it behind the granted press.
            pending <= key_pulse | (pending & ~grant_vec);
            if (grant_en) last <= grant_idx;
            if (push) begin
                code_mem[wr_ptr] <= grant_idx;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

`ifdef KEY_EVT_GAP_EN
    logic [15:0] gap_mem [FIFO_DEPTH];
    logic [15:0] gap_cnt;
    logic [15:0] gap_val;
    logic        gap_seen;

    // gap_cnt counts cycles since the last grant minus one, so the reported gap is +1.
    always_comb begin
        if (!gap_seen || gap_cnt == 16'hFFFF) gap_val = 16'hFFFF;
        else                                  gap_val = gap_cnt + 16'd1;
    end

    assign evt_gap = gap_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt  <= '0;
            gap_seen <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) gap_mem[i] <= '0;
        end else begin
            if (grant_en) begin
                gap_cnt          <= '0;
                gap_seen         <= 1'b1;
                gap_mem[wr_ptr]  <= gap_val;
            end else if (gap_cnt != 16'hFFFF) begin
                gap_cnt <= gap_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
Collects one-cycle press pulses from the per-key debouncers of the code-entry keypad. Holds one pending press per key and grants pending presses round-robin, one per cycle. Each grant writes the key index into a small event FIFO. The code-compare FSM reads the FIFO through a valid/ready handshake, so simultaneous or back-to-back presses are never merged and are serialised in fair order.

Parameters:
NUM_KEYS, 4, number of debounced key inputs (2..16)
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
KW, $clog2(NUM_KEYS), width of key index code (localparam, min 1)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
key_pulse  in  NUM_KEYS  one-cycle press pulses from debouncers, bit i = key i
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_code  out  KW  key index at FIFO head (don't-care when evt_valid=0)
pending  out  NUM_KEYS  per-key pending-press flags (registered)
overrun  out  1  sticky: a press was lost
clr_overrun  in  1  clears overrun

Behaviour:
- Reset values: pending=0, FIFO empty, evt_valid=0, evt_code=0, overrun=0, rr pointer last=NUM_KEYS-1 (key 0 has top priority after reset). Reset mid-operation discards all pending and queued events.
- Pending set: key_pulse[i]=1 at edge -> pending[i]=1.
- Grant (combinational from registered pending):
  - Grant when pending!=0 and fifo_count<FIFO_DEPTH.
  - Pick the first set bit searching upward, cyclically, from last+1.
  - At the edge: write the index into the FIFO, clear pending[g], set last=g.
  - At most one grant per cycle.
- Full FIFO: no grant. A pop in the same cycle does NOT enable a grant (no full-bypass); the grant occurs the next cycle.
- Simultaneous pulse and grant on the same key i: pending[i] stays 1 (new press queued behind the granted one). No overrun.
- Pulse on key i while pending[i]=1 and i is not granted that cycle: press dropped, overrun<=1.
- overrun: set has priority over clr_overrun in the same cycle. Cleared by rst or clr_overrun.
- FIFO:
  - Pop when evt_valid&&evt_ready.
  - Push and pop in the same cycle allowed; count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_count is log2(FIFO_DEPTH)+1 bits.
  - evt_valid=(fifo_count!=0).
  - evt_code driven from the registered head entry; no combinational path from key_pulse.
- Latency (empty FIFO, no contention): pulse in cycle 0 -> pending high cycle 1 -> evt_valid/evt_code valid cycle 2.
- evt_ready while evt_valid=0 is ignored.
- evt_code holds stable while evt_valid=1 and evt_ready=0.

Optional Feature:
KEY_EVT_GAP_EN:
- Defined:
  - Adds output evt_gap [15:0], stored per FIFO entry alongside the code.
  - Value = clk cycles between this grant and the previous grant, saturating at 16'hFFFF.
  - The first grant after reset reports 16'hFFFF.
  - The free-running gap counter resets to 0 on each grant.
  - Lets the FSM enforce an inter-digit timeout.
- Undefined: no evt_gap port, no counter or storage; all other behaviour identical.

Test Plan:
- Single press: after reset, key_pulse=4'b0100 in cycle 0, evt_ready=0 -> pending=4'b0100 cycle 1; evt_valid=1, evt_code=2 cycle 2; pending=0.
- Round-robin: key_pulse=4'b1111 in one cycle, evt_ready=1 -> codes 0,1,2,3 on consecutive cycles. Then pulses 4'b0011 -> 0 then 1 (last=3 wraps to 0).
- Fairness after grant: last grant=1, pulses 4'b0011 -> order 0 then 1 (search starts at 2, wraps to 0 before 1).
- Full FIFO: evt_ready=0, presses on keys 0..3 then key 0 again -> 4 entries queued. Fifth press stays pending=4'b0001, no grant. Raise evt_ready one cycle -> pop, key 0 granted the following cycle.
- Overrun: FIFO full, pending[3]=1, pulse key 3 again -> overrun=1 next cycle; stays 1; clr_overrun=1 -> 0. Also: clr_overrun and new drop in the same cycle -> overrun stays 1.
- Reset mid-operation: 3 events queued plus pending=4'b1000, assert rst one cycle -> evt_valid=0, pending=0, overrun=0. Next press on key 3 returns code 3 at latency 2. With KEY_EVT_GAP_EN this event reports evt_gap=16'hFFFF.
